data_path: RTL and testbench

- Single-cycle, 32-bit datapath of the KGP mini-RISC processor.
- Contains the PC, instruction memory, 32x32 register file, immediate mux, ALU, carry flag, data memory, write-back mux and branch/next-PC logic.
- The external control unit decodes opcode_out/func_out and drives all control inputs.
- Internal nodes are brought out for debug.

---
 rtl/data_path.sv | 137 +++++++++++++
 tb/tb_data_path.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// KGP mini-RISC single-cycle datapath: fetch, register file, ALU, carry flag, data memory,
// write-back and next-PC selection. An external decoder drives every control input.
module data_path #(
    parameter int    IMEM_DEPTH = 1024,
    parameter int    DMEM_DEPTH = 1024,
    parameter string IMEM_INIT  = "imem.mem",
    parameter string DMEM_INIT  = "dmem.mem"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  reg_write,
    input  logic        imm_mux_ctrl,
    input  logic        alu_mux_ctrl,
    input  logic [3:0]  alu_op,
    input  logic        dmem_enable,
    input  logic        dmem_write_enable,
    input  logic [1:0]  reg_write_mux_ctrl,
    input  logic [4:0]  br_op,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  func_out,
    output logic [31:0] res_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] imm_res_out,
    output logic [31:0] pc,
    output logic [31:0] pc_new,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [31:0] reg_val1,
    output logic [31:0] reg_val2
);
    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [31:0] imem_q [IMEM_DEPTH];
    logic [31:0] dmem_q [DMEM_DEPTH];
    logic [31:0] regs_q [32];
    logic [31:0] pc_q, pc_d, pc_plus1, alu_b, diff_x, dmem_rdata, jmp_tgt, br_tgt;
    logic [32:0] sum;
    logic [4:0]  diff_idx, wr_addr;
    logic [IAW-1:0] iaddr;
    logic [DAW-1:0] daddr;
    logic        carry_q;

    assign pc          = pc_q;
    assign pc_new      = pc_d;
    assign pc_plus1    = pc_q + 32'd1;
    assign iaddr       = IAW'(pc_q % IMEM_DEPTH);
    assign instr_out   = imem_q[iaddr];
    assign opcode_out  = instr_out[31:26];
    assign func_out    = instr_out[5:0];
    assign rs          = instr_out[25:21];
    assign rt          = instr_out[20:16];
    assign reg_val1    = regs_q[rs];
    assign reg_val2    = regs_q[rt];
    assign imm_res_out = imm_mux_ctrl ? {{16{instr_out[15]}}, instr_out[15:0]}
                                      : {27'd0, instr_out[10:6]};
    assign alu_b       = alu_mux_ctrl ? imm_res_out : reg_val2;
    assign sum         = {1'b0, reg_val1} + {1'b0, alu_b};
    assign diff_x      = reg_val1 ^ alu_b;

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        diff_idx = 5'd0;
        for (int i = 31; i >= 0; i--)
            if (diff_x[i]) diff_idx = 5'(i);
    end

    always_comb begin
        case (alu_op)
            4'b0000: alu_res_out = sum[31:0];
            4'b0001: alu_res_out = 32'd0 - alu_b;
            4'b0010: alu_res_out = reg_val1 & alu_b;
            4'b0011: alu_res_out = diff_x;
            4'b0100: alu_res_out = reg_val1 << alu_b[4:0];
            4'b0101: alu_res_out = reg_val1 >> alu_b[4:0];
            4'b0110: alu_res_out = $unsigned($signed(reg_val1) >>> alu_b[4:0]);
            4'b0111: alu_res_out = {27'd0, diff_idx};
            default: alu_res_out = 32'd0;
        endcase
    end

    assign daddr      = DAW'(alu_res_out % DMEM_DEPTH);
    assign dmem_rdata = dmem_enable ? dmem_q[daddr] : 32'd0;

    always_comb begin
        case (reg_write_mux_ctrl)
            2'b00:   res_out = pc_plus1;
            2'b01:   res_out = dmem_rdata;
            2'b10:   res_out = alu_res_out;
            default: res_out = 32'd0;
        endcase
    end

    assign jmp_tgt = {6'd0, instr_out[25:0]};
    assign br_tgt  = pc_plus1 + {{16{instr_out[15]}}, instr_out[15:0]};

    always_comb begin
        case (br_op)
            5'd1, 5'd6: pc_d = jmp_tgt;
            5'd2:       pc_d = reg_val1;
            5'd3:       pc_d = reg_val1[31]        ? br_tgt : pc_plus1;
            5'd4:       pc_d = (reg_val1 == 32'd0) ? br_tgt : pc_plus1;
            5'd5:       pc_d = (reg_val1 != 32'd0) ? br_tgt : pc_plus1;
            5'd7:       pc_d = carry_q             ? jmp_tgt : pc_plus1;
            5'd8:       pc_d = !carry_q            ? jmp_tgt : pc_plus1;
            default:    pc_d = pc_plus1;
        endcase
    end

    always_comb begin
        case (reg_write)
            2'b01:   wr_addr = rs;
            2'b10:   wr_addr = rt;
            default: wr_addr = 5'd31;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= 32'd0;
            carry_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (reg_write != 2'b00) begin
                regs_q[wr_addr] <= res_out;
                if (alu_op == 4'b0000) carry_q <= sum[32];
            end
        end
    end

    // Memory contents survive reset, but a store is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && dmem_enable && dmem_write_enable) dmem_q[daddr] <= reg_val2;
    end
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed program table with fixed expectations, then random control
// and instructions checked against an architectural model of the mini-RISC datapath.
module tb_data_path;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reg_write, reg_write_mux_ctrl;
    logic        imm_mux_ctrl, alu_mux_ctrl, dmem_enable, dmem_write_enable;
    logic [3:0]  alu_op;
    logic [4:0]  br_op;
    logic [31:0] instr_out, res_out, alu_res_out, imm_res_out, pc, pc_new, reg_val1, reg_val2;
    logic [5:0]  opcode_out, func_out;
    logic [4:0]  rs, rt;

    always #5 clk = ~clk;

    data_path #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .IMEM_INIT(""), .DMEM_INIT("")) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .imm_mux_ctrl(imm_mux_ctrl),
        .alu_mux_ctrl(alu_mux_ctrl), .alu_op(alu_op), .dmem_enable(dmem_enable),
        .dmem_write_enable(dmem_write_enable), .reg_write_mux_ctrl(reg_write_mux_ctrl),
        .br_op(br_op), .instr_out(instr_out), .opcode_out(opcode_out), .func_out(func_out),
        .res_out(res_out), .alu_res_out(alu_res_out), .imm_res_out(imm_res_out), .pc(pc),
        .pc_new(pc_new), .rs(rs), .rt(rt), .reg_val1(reg_val1), .reg_val2(reg_val2));

    typedef struct packed {
        logic [1:0] rw; logic imm; logic amux; logic [3:0] aop;
        logic den; logic dwe; logic [1:0] wb; logic [4:0] br;
    } ctrl_t;
    typedef struct {
        logic [31:0] pc; logic [31:0] instr; ctrl_t c;
        logic [31:0] res; logic [31:0] alu; logic [31:0] pcn;
    } vec_t;
    typedef struct packed {
        logic [31:0] instr, res, alu, imm, pcn, rv1, rv2;
    } exp_t;

    int total = 0, bad = 0, tag = 0;
    logic [31:0] m_pc, m_reg [32], m_imem [1024], m_dmem [1024];
    logic        m_carry;
    vec_t        tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, tag, act, want);
        end
    endtask

    function automatic ctrl_t mc(input int rw, imm, amux, aop, den, dwe, wb, br);
        ctrl_t c;
        c.rw = 2'(rw); c.imm = 1'(imm); c.amux = 1'(amux); c.aop = 4'(aop);
        c.den = 1'(den); c.dwe = 1'(dwe); c.wb = 2'(wb); c.br = 5'(br);
        return c;
    endfunction

    function automatic logic [31:0] ii(input int r_s, r_t, imm16);
        return {6'd0, 5'(r_s), 5'(r_t), 16'(imm16)};
    endfunction

    function automatic logic [31:0] jj(input int tgt);
        return {6'd0, 26'(tgt)};
    endfunction

    function automatic vec_t mv(input int p, input logic [31:0] ins, input ctrl_t c,
                                input logic [31:0] res, alu, pcn);
        vec_t v;
        v.pc = 32'(p); v.instr = ins; v.c = c; v.res = res; v.alu = alu; v.pcn = pcn;
        return v;
    endfunction

    function automatic ctrl_t rnd_ctrl();
        ctrl_t c;
        c.rw = 2'($urandom); c.imm = 1'($urandom); c.amux = 1'($urandom);
        c.aop = 4'($urandom_range(0, 9)); c.den = 1'($urandom); c.dwe = 1'($urandom);
        c.wb = 2'($urandom);
        c.br = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
        return c;
    endfunction

    task automatic drive(input ctrl_t c);
        reg_write = c.rw; imm_mux_ctrl = c.imm; alu_mux_ctrl = c.amux; alu_op = c.aop;
        dmem_enable = c.den; dmem_write_enable = c.dwe; reg_write_mux_ctrl = c.wb; br_op = c.br;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic mdl_reset();
        m_pc = 0; m_carry = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
    endtask

    // One architectural instruction step: returns the visible values, then retires it.
    task automatic mdl(input ctrl_t c, output exp_t e);
        logic [31:0] ins, a, b, rb, sx, r, rd, wbv, pcn, x, p1;
        longint s;
        int sh, j, addr, dst;
        ins = m_imem[m_pc % 1024];
        a = m_reg[ins[25:21]]; rb = m_reg[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        e.imm = c.imm ? sx : {27'd0, ins[10:6]};
        b = c.amux ? e.imm : rb;
        s = longint'(a) + longint'(b);
        sh = int'(b[4:0]);
        case (c.aop)
            4'd0: r = s[31:0];
            4'd1: r = 32'd0 - b;
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: r = a << sh;
            4'd5: r = a >> sh;
            4'd6: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd7: begin
                x = a ^ b; r = 0;
                if (x != 0) begin
                    j = 0;
                    while (!x[j]) j++;
                    r = 32'(j);
                end
            end
            default: r = 0;
        endcase
        addr = int'(r % 1024);
        rd = c.den ? m_dmem[addr] : 32'd0;
        p1 = m_pc + 1;
        case (c.wb)
            2'd0: wbv = p1;
            2'd1: wbv = rd;
            2'd2: wbv = r;
            default: wbv = 0;
        endcase
        case (int'(c.br))
            1, 6: pcn = {6'd0, ins[25:0]};
            2: pcn = a;
            3: pcn = a[31] ? p1 + sx : p1;
            4: pcn = (a == 0) ? p1 + sx : p1;
            5: pcn = (a != 0) ? p1 + sx : p1;
            7: pcn = m_carry ? {6'd0, ins[25:0]} : p1;
            8: pcn = !m_carry ? {6'd0, ins[25:0]} : p1;
            default: pcn = p1;
        endcase
        e.instr = ins; e.res = wbv; e.alu = r; e.pcn = pcn; e.rv1 = a; e.rv2 = rb;
        if (c.rw != 0) begin
            dst = (c.rw == 1) ? int'(ins[25:21]) : (c.rw == 2) ? int'(ins[20:16]) : 31;
            m_reg[dst] = wbv;
            if (c.aop == 0) m_carry = s[32];
        end
        if (c.den && c.dwe) m_dmem[addr] = rb;
        m_pc = pcn;
    endtask

    task automatic rnd_run(input int n);
        ctrl_t c;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            tag++;
            c = rnd_ctrl();
            drive(c); #1;
            mdl(c, e);
            chk("pc", pc, e.pcn == e.pcn ? pc_model_prev() : 32'd0);
            chk("instr", instr_out, e.instr);
            chk("reg_val1", reg_val1, e.rv1);
            chk("reg_val2", reg_val2, e.rv2);
            chk("imm", imm_res_out, e.imm);
            chk("alu", alu_res_out, e.alu);
            chk("res", res_out, e.res);
            chk("pc_new", pc_new, e.pcn);
            cycle();
        end
    endtask

    logic [31:0] pc_before;
    function automatic logic [31:0] pc_model_prev();
        return pc_before;
    endfunction

    initial begin
        ctrl_t c, xor0, lw, add, addi, bl, sw, swoff;
        exp_t  e;
        rst = 1'b0;
        xor0  = mc(1, 0, 0, 3, 0, 0, 2, 0);
        lw    = mc(2, 1, 1, 0, 1, 0, 1, 0);
        add   = mc(1, 0, 0, 0, 0, 0, 2, 0);
        addi  = mc(2, 1, 1, 0, 0, 0, 2, 0);
        bl    = mc(3, 0, 0, 15, 0, 0, 0, 6);
        sw    = mc(0, 1, 1, 0, 1, 1, 2, 0);
        swoff = mc(0, 1, 1, 0, 0, 1, 1, 0);
        drive(mc(0, 0, 0, 0, 0, 0, 0, 0));

        tbl[0]  = mv(0,    ii(0, 0, 0),       xor0, 0, 0, 1);
        tbl[1]  = mv(1,    ii(5, 1, 0),       lw, 5, 0, 2);
        tbl[2]  = mv(2,    ii(5, 2, 1),       lw, 7, 1, 3);
        tbl[3]  = mv(3,    ii(5, 3, 2),       lw, 11, 2, 4);
        tbl[4]  = mv(4,    ii(5, 4, 3),       lw, 13, 3, 5);
        tbl[5]  = mv(5,    ii(1, 2, 0),       add, 12, 12, 6);
        tbl[6]  = mv(6,    ii(3, 4, 0),       add, 24, 24, 7);
        tbl[7]  = mv(7,    ii(1, 3, 0),       add, 36, 36, 8);
        tbl[8]  = mv(8,    ii(5, 6, 4),       lw, 32'hFFFF_FFFF, 4, 9);
        tbl[9]  = mv(9,    ii(6, 7, 1),       addi, 0, 0, 10);
        tbl[10] = mv(10,   jj(32'h20),        mc(0, 1, 0, 15, 0, 0, 3, 8), 0, 0, 11);
        tbl[11] = mv(11,   jj(32'h20),        mc(0, 1, 0, 15, 0, 0, 3, 7), 0, 0, 32'h20);
        tbl[12] = mv('h20, ii(0, 0, 'hFFFE),  mc(0, 1, 0, 15, 0, 0, 3, 4), 0, 0, 32'h1F);
        tbl[13] = mv('h1F, ii(1, 0, 8),       mc(0, 1, 0, 15, 0, 0, 3, 5), 0, 0, 32'h28);
        tbl[14] = mv('h28, ii(1, 0, 'hFFFE),  mc(0, 1, 0, 15, 0, 0, 3, 4), 0, 0, 32'h29);
        tbl[15] = mv('h29, jj(32'h40),        bl, 32'h2A, 0, 32'h40);
        tbl[16] = mv('h40, ii(31, 0, 0),      mc(0, 1, 0, 15, 0, 0, 3, 2), 0, 0, 32'h2A);
        tbl[17] = mv('h2A, ii(5, 2, 5),       lw, 32'hDEAD_BEEF, 5, 32'h2B);
        tbl[18] = mv('h2B, ii(5, 2, 8),       sw, 8, 8, 32'h2C);
        tbl[19] = mv('h2C, ii(5, 8, 8),       lw, 32'hDEAD_BEEF, 8, 32'h2D);
        tbl[20] = mv('h2D, ii(5, 1, 9),       swoff, 0, 9, 32'h2E);
        tbl[21] = mv('h2E, ii(5, 9, 9),       lw, 32'h1234_5678, 9, 32'h2F);
        tbl[22] = mv('h2F, ii(6, 0, 3),       mc(0, 1, 0, 15, 0, 0, 3, 3), 0, 0, 32'h33);
        tbl[23] = mv('h33, ii(1, 0, 3),       mc(0, 1, 0, 15, 0, 0, 3, 3), 0, 0, 32'h34);

        for (int i = 0; i < 1024; i++) begin
            m_imem[i] = $urandom; m_dmem[i] = $urandom;
        end
        foreach (tbl[i]) m_imem[tbl[i].pc % 1024] = tbl[i].instr;
        m_dmem[0] = 5; m_dmem[1] = 7; m_dmem[2] = 11; m_dmem[3] = 13;
        m_dmem[4] = 32'hFFFF_FFFF; m_dmem[5] = 32'hDEAD_BEEF; m_dmem[8] = 0;
        m_dmem[9] = 32'h1234_5678;
        for (int i = 0; i < 1024; i++) begin
            dut.imem_q[i] = m_imem[i]; dut.dmem_q[i] = m_dmem[i];
        end

        // Reset held two cycles while register writes are requested; reset must win.
        drive(mc(3, 0, 0, 0, 0, 0, 2, 7));
        cycle(); cycle();
        mdl_reset();
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr_out, m_imem[0]);
        chk("rst_rv1", reg_val1, 32'd0);
        chk("rst_rv2", reg_val2, 32'd0);
        chk("rst_carry_bcy", pc_new, 32'd1);

        rst = 1'b1;
        foreach (tbl[i]) begin
            tag = i;
            drive(tbl[i].c); #1;
            chk("tbl_pc", pc, tbl[i].pc);
            chk("tbl_instr", instr_out, tbl[i].instr);
            chk("tbl_res", res_out, tbl[i].res);
            chk("tbl_alu", alu_res_out, tbl[i].alu);
            chk("tbl_pc_new", pc_new, tbl[i].pcn);
            mdl(tbl[i].c, e);
            cycle();
        end

        tag = 100;
        pc_before = m_pc;
        for (int i = 0; i < 400; i++) begin
            pc_before = m_pc;
            rnd_run(1);
        end

        // Second reset from a dirty state, with random writes requested during it.
        rst = 1'b0;
        c = rnd_ctrl(); c.den = 1'b0; c.rw = 2'd3;
        drive(c);
        cycle();
        c = rnd_ctrl(); c.den = 1'b0;
        drive(c);
        cycle();
        mdl_reset();
        chk("rst2_pc", pc, 32'd0);
        chk("rst2_rv1", reg_val1, 32'd0);
        chk("rst2_rv2", reg_val2, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pc_before = m_pc;
            rnd_run(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
